writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_if.sv | 50 +++++
 rtl/writeback_unit.sv | 130 +++++++++++++
 tb/tb_writeback_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Writeback unit bus: ALU result, load handshake, register-file write port and pending query.
// With WB_FORWARD_EN defined the same-cycle bypass signals fwd_* are added.
interface writeback_unit_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;

    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;

    logic        register_write_en;
    logic [4:0]  rd_address;
    logic [31:0] register_write_data;

    logic [4:0]  query_address;
    logic        query_pending;

`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_address;
    logic [31:0] fwd_data;

    modport master (
        output alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data, query_address,
        input  alu_stall, load_ready, register_write_en, rd_address, register_write_data,
               query_pending, fwd_valid, fwd_address, fwd_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data, query_address,
        output alu_stall, load_ready, register_write_en, rd_address, register_write_data,
               query_pending, fwd_valid, fwd_address, fwd_data
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data, query_address,
        input  alu_stall, load_ready, register_write_en, rd_address, register_write_data,
               query_pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data, query_address,
        output alu_stall, load_ready, register_write_en, rd_address, register_write_data,
               query_pending
    );
`endif
endinterface

// File: rtl/writeback_unit.sv
// Arbitrates ALU and load results onto one register-file write port, buffering loads in a 2-entry FIFO.
// Optional macro WB_FORWARD_EN exposes the pre-register selected write on fwd_* for bypass.
module writeback_unit (
    input logic              clk,
    input logic              rst,
    writeback_unit_if.slave  wb
);
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_FIFO,
        SEL_ALU,
        SEL_LOAD
    } sel_t;

    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic [1:0]  entry_valid;

    sel_t        sel;
    logic        load_ready_i;
    logic        load_acc;
    logic        push;
    logic        pop;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    logic        reg_en;
    logic [4:0]  reg_rd;
    logic [31:0] reg_data;

    assign load_ready_i  = (count < 2'd2);
    assign load_acc      = wb.load_valid && load_ready_i;
    assign wb.load_ready = load_ready_i;
    assign wb.alu_stall  = wb.alu_valid && (count == 2'd2);

    // A full FIFO outranks the ALU so loads cannot be starved indefinitely.
    always_comb begin
        sel      = SEL_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (count == 2'd2) begin
            sel      = SEL_FIFO;
            sel_rd   = fifo_rd[rd_ptr];
            sel_data = fifo_data[rd_ptr];
        end else if (wb.alu_valid) begin
            sel      = SEL_ALU;
            sel_rd   = wb.alu_rd;
            sel_data = wb.alu_data;
        end else if (count != 2'd0) begin
            sel      = SEL_FIFO;
            sel_rd   = fifo_rd[rd_ptr];
            sel_data = fifo_data[rd_ptr];
        end else if (load_acc) begin
            sel      = SEL_LOAD;
            sel_rd   = wb.load_rd;
            sel_data = wb.load_data;
        end
    end

    assign push = load_acc && (sel != SEL_LOAD);
    assign pop  = (sel == SEL_FIFO);

    always_comb begin
        entry_valid = 2'b00;
        if (count == 2'd2) begin
            entry_valid = 2'b11;
        end else if (count == 2'd1) begin
            entry_valid[rd_ptr] = 1'b1;
        end
    end

    assign wb.query_pending = (wb.query_address != 5'd0) &&
                              ((entry_valid[0] && (fifo_rd[0] == wb.query_address)) ||
                               (entry_valid[1] && (fifo_rd[1] == wb.query_address)) ||
                               (reg_en && (reg_rd == wb.query_address)));

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= wb.load_rd;
            fifo_data[wr_ptr] <= wb.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            reg_en   <= 1'b0;
            reg_rd   <= 5'd0;
            reg_data <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end

            // Writes to x0 still consume their slot but never strobe the register file.
            if (sel != SEL_NONE) begin
                reg_en   <= (sel_rd != 5'd0);
                reg_rd   <= sel_rd;
                reg_data <= sel_data;
            end else begin
                reg_en   <= 1'b0;
            end
        end
    end

    assign wb.register_write_en   = reg_en;
    assign wb.rd_address          = reg_rd;
    assign wb.register_write_data = reg_data;

`ifdef WB_FORWARD_EN
    assign wb.fwd_valid   = (sel != SEL_NONE) && (sel_rd != 5'd0);
    assign wb.fwd_address = sel_rd;
    assign wb.fwd_data    = sel_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic against a queue model.
module tb_writeback_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_unit_if wb_if ();

    writeback_unit dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if.slave)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    // Model state: queued loads in acceptance order and the expected write-port registers.
    entry_t      q[$];
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_known = 0;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] qa);
        bit     pend;
        bit     has_sel;
        bit     acc;
        entry_t s;
        @(negedge clk);
        if (m_known) begin
            check_val("write_en", {31'd0, wb_if.register_write_en}, {31'd0, m_en});
            check_val("rd_address", {27'd0, wb_if.rd_address}, {27'd0, m_rd});
            check_val("write_data", wb_if.register_write_data, m_data);
        end
        rst                 = r;
        wb_if.alu_valid     = av;
        wb_if.alu_rd        = ard;
        wb_if.alu_data      = ad;
        wb_if.load_valid    = lv;
        wb_if.load_rd       = lrd;
        wb_if.load_data     = ld;
        wb_if.query_address = qa;
        #1;
        if (!r && m_known) begin
            check_val("load_ready", {31'd0, wb_if.load_ready}, {31'd0, (q.size() < 2)});
            check_val("alu_stall", {31'd0, wb_if.alu_stall}, {31'd0, (av && q.size() == 2)});
            pend = 0;
            if (qa != 5'd0) begin
                foreach (q[i]) if (q[i].rd == qa) pend = 1;
                if (m_en && m_rd == qa) pend = 1;
            end
            check_val("query_pending", {31'd0, wb_if.query_pending}, {31'd0, pend});
        end
        if (r) begin
            q.delete();
            m_en    = 0;
            m_rd    = '0;
            m_data  = '0;
            m_known = 1;
        end else begin
            acc     = lv && (q.size() < 2);
            has_sel = 1;
            s       = '0;
            if (q.size() == 2) begin
                s = q.pop_front();
            end else if (av) begin
                s = '{ard, ad};
                if (acc) q.push_back('{lrd, ld});
            end else if (q.size() > 0) begin
                s = q.pop_front();
                if (acc) q.push_back('{lrd, ld});
            end else if (acc) begin
                s = '{lrd, ld};
            end else begin
                has_sel = 0;
            end
            if (has_sel) begin
                m_en   = (s.rd != 5'd0);
                m_rd   = s.rd;
                m_data = s.data;
            end else begin
                m_en = 0;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic [4:0] qa);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, qa);
    endtask

    initial begin
        bit          av, lv, r;
        logic [4:0]  ard, lrd, qa;
        logic [31:0] ad, ld;
        bit          alu_hold, load_hold;

        rst = 1'b1;
        wb_if.alu_valid = 0; wb_if.alu_rd = 0; wb_if.alu_data = 0;
        wb_if.load_valid = 0; wb_if.load_rd = 0; wb_if.load_data = 0;
        wb_if.query_address = 0;

        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        #1;
        check_val("reset_en", {31'd0, wb_if.register_write_en}, 32'd0);
        check_val("reset_rd", {27'd0, wb_if.rd_address}, 32'd0);
        check_val("reset_data", wb_if.register_write_data, 32'd0);
        idle(5'd0);

        // ALU-only write
        step(0, 1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'd0, 5'd0);
        #1;
        check_val("alu_only_en", {31'd0, wb_if.register_write_en}, 32'd1);
        check_val("alu_only_rd", {27'd0, wb_if.rd_address}, 32'd5);
        check_val("alu_only_data", wb_if.register_write_data, 32'h1234_5678);
        idle(5'd0);

        // ALU and load collide
        step(0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 5'd0);
        #1;
        check_val("collide_rd1", {27'd0, wb_if.rd_address}, 32'd3);
        check_val("collide_data1", wb_if.register_write_data, 32'hA);
        idle(5'd0);
        #1;
        check_val("collide_rd2", {27'd0, wb_if.rd_address}, 32'd4);
        check_val("collide_data2", wb_if.register_write_data, 32'hB);
        idle(5'd0);
        #1;
        check_val("collide_drained", {31'd0, wb_if.load_ready}, 32'd1);

        // ALU held high while loads 6 and 7 fill the FIFO
        step(0, 1, 5'd1, 32'h111, 1, 5'd6, 32'h66, 5'd0);
        step(0, 1, 5'd2, 32'h222, 1, 5'd7, 32'h77, 5'd0);
        #1;
        check_val("starve_ready", {31'd0, wb_if.load_ready}, 32'd0);
        check_val("starve_stall", {31'd0, wb_if.alu_stall}, 32'd1);
        step(0, 1, 5'd8, 32'h888, 0, 5'd0, 32'd0, 5'd0);
        #1;
        check_val("starve_first_rd", {27'd0, wb_if.rd_address}, 32'd6);
        step(0, 1, 5'd8, 32'h888, 0, 5'd0, 32'd0, 5'd0);
        idle(5'd0);
        idle(5'd0);

        // Load to x0 never strobes, x0 is never pending
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0);
        #1;
        check_val("x0_en", {31'd0, wb_if.register_write_en}, 32'd0);
        check_val("x0_query", {31'd0, wb_if.query_pending}, 32'd0);
        idle(5'd0);

        // Load r9 queued behind the ALU, tracked by query
        step(0, 1, 5'd2, 32'h2222, 1, 5'd9, 32'h9999, 5'd9);
        idle(5'd9);
        idle(5'd9);
        idle(5'd9);

        // Reset with a full FIFO discards it
        step(0, 1, 5'd10, 32'h10, 1, 5'd11, 32'h11, 5'd0);
        step(0, 1, 5'd12, 32'h12, 1, 5'd13, 32'h13, 5'd0);
        step(1, 1, 5'd12, 32'h12, 0, 5'd0, 32'd0, 5'd0);
        step(0, 1, 5'd14, 32'h14, 0, 5'd0, 32'd0, 5'd11);
        idle(5'd13);
        idle(5'd0);

        // Random traffic; stalled ALU results and unaccepted loads are held
        alu_hold = 0; load_hold = 0;
        av = 0; ard = 0; ad = 0; lv = 0; lrd = 0; ld = 0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 79) == 0);
            if (r) begin
                alu_hold = 0;
                load_hold = 0;
            end
            if (!alu_hold) begin
                av  = ($urandom_range(0, 99) < 55);
                ard = 5'($urandom_range(0, 31));
                ad  = $urandom;
            end
            if (!load_hold) begin
                lv  = ($urandom_range(0, 99) < 60);
                lrd = 5'($urandom_range(0, 31));
                ld  = $urandom;
            end
            qa = 5'($urandom_range(0, 31));
            if (!r && q.size() > 0 && $urandom_range(0, 1) == 1) qa = q[0].rd;
            alu_hold  = !r && av && (q.size() == 2);
            load_hold = !r && lv && (q.size() >= 2);
            step(r, av, ard, ad, lv, lrd, ld, qa);
        end
        idle(5'd0);
        idle(5'd0);
        idle(5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
